// File: rtl/mult_pipe.sv
// mult_pipe: pipelined signed/unsigned multiply and multiply-accumulate for
// the execute stage, feeding the HI/LO writeback path.
//
// Datapath: radix-4 Booth partial products -> 3:2 carry-save tree at 2W+2
// bits -> final carry-propagate add truncated to 2W bits.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   flush           drop everything in flight; blocks accept this cycle
//   in_valid/ready  input handshake; op, src0, src1, acc_in, tag_in sampled on accept
//   op              000 MULT, 001 MULTU, 010 MADD, 011 MADDU, 100 MSUB, 101 MSUBU
//   out_valid/ready output handshake; res, tag_out registered
module mult_pipe #(
  parameter int W      = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [W-1:0]     src0,
  input  logic [W-1:0]     src1,
  input  logic [2*W-1:0]   acc_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   res,
  output logic [TAG_W-1:0] tag_out
);
  localparam int XW = 2*W + 2;    // internal tree width
  localparam int ND = (W + 2) / 2; // Booth digits over the W+2-bit multiplier
  localparam int NR = ND + 2;     // tree rows: partials + negate-correction + accumulator

  logic              advance, accept;
  logic [STAGES:1]   vld_pipe;
  logic [XW-1:0]     cs_sum, cs_car;
  logic [TAG_W-1:0]  tag_q [STAGES];

  // The whole pipe moves as one unit; a full output slot that is not taken
  // freezes every stage.
  assign advance   = !out_valid | out_ready;
  assign in_ready  = advance & !flush;
  assign accept    = in_valid & in_ready;
  assign out_valid = vld_pipe[STAGES];
  assign tag_out   = tag_q[STAGES-1];

  // Booth recoding and carry-save reduction.
  always_comb begin
    logic [XW-1:0] ax, mag, corr;
    logic [W+2:0]  bz;
    logic          neg, one, two, sub, acc_en;
    logic [XW-1:0] rows [NR];
    logic [XW-1:0] nxt  [NR];
    int            n, k;

    sub    = (op == 3'b100) || (op == 3'b101);
    acc_en = (op[2:1] == 2'b01) || sub;
    // op[0] selects zero- vs sign-extension; the extra bit makes unsigned
    // operands behave as non-negative W+1-bit values.
    ax   = {{(W+2){~op[0] & src0[W-1]}}, src0};
    bz   = {{2{~op[0] & src1[W-1]}}, src1, 1'b0};
    corr = '0;

    // MSUB folds into the tree by flipping every digit's sign, so the
    // accumulator sees -P without a separate negate stage. Negation is
    // one's complement here plus a +1 in the correction row.
    for (int i = 0; i < ND; i++) begin
      one  = bz[2*i+1] ^ bz[2*i];
      two  = (bz[2*i+2] & ~bz[2*i+1] & ~bz[2*i]) | (~bz[2*i+2] & bz[2*i+1] & bz[2*i]);
      neg  = bz[2*i+2] ^ sub;
      mag  = one ? ax : (two ? ax << 1 : '0);
      rows[i]   = (neg ? ~mag : mag) << (2*i);
      corr[2*i] = neg;
    end
    rows[ND]   = corr;
    rows[ND+1] = acc_en ? {2'b00, acc_in} : '0;

    // Wallace-style levels: each group of three rows becomes sum + carry,
    // leftover rows pass straight through, until two rows remain.
    n = NR;
    for (int lvl = 0; lvl < NR; lvl++) begin
      if (n > 2) begin
        nxt = rows;
        k   = 0;
        for (int g = 0; g < NR/3; g++) begin
          if (3*g + 2 < n) begin
            nxt[k]   = rows[3*g] ^ rows[3*g+1] ^ rows[3*g+2];
            nxt[k+1] = ((rows[3*g] & rows[3*g+1]) | (rows[3*g] & rows[3*g+2]) |
                        (rows[3*g+1] & rows[3*g+2])) << 1;
            k = k + 2;
          end
        end
        for (int j = 0; j < NR; j++) begin
          if (j >= 3*(n/3) && j < n) begin
            nxt[k] = rows[j];
            k = k + 1;
          end
        end
        rows = nxt;
        n    = k;
      end
    end
    cs_sum = rows[0];
    cs_car = rows[1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) vld_pipe <= '0;
    else if (advance)    vld_pipe <= (vld_pipe << 1) | STAGES'(accept);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) tag_q[i] <= '0;
    end else if (advance) begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < STAGES; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Carry-save pair rides the middle stages; the last stage owns the CPA
  // so res comes straight from a register.
  generate
    if (STAGES == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (!rst_n)       res <= '0;
        else if (advance) res <= (2*W)'(cs_sum + cs_car);
      end
    end else begin : g_multi
      logic [XW-1:0] s_q [STAGES-1];
      logic [XW-1:0] c_q [STAGES-1];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < STAGES-1; i++) begin
            s_q[i] <= '0;
            c_q[i] <= '0;
          end
          res <= '0;
        end else if (advance) begin
          s_q[0] <= cs_sum;
          c_q[0] <= cs_car;
          for (int i = 1; i < STAGES-1; i++) begin
            s_q[i] <= s_q[i-1];
            c_q[i] <= c_q[i-1];
          end
          res <= (2*W)'(s_q[STAGES-2] + c_q[STAGES-2]);
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_mult_pipe.sv
// Bench for mult_pipe: default config (W=32, STAGES=2) with directed vectors,
// backpressure and flush sequences; W=8/STAGES=1 and W=16/STAGES=4 instances
// share one random stimulus and are checked against a behavioural model.
module tb_mult_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // default instance
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  op;
  logic [31:0] src0, src1;
  logic [63:0] acc, res;
  logic [4:0]  tag, tag_out;

  // sweep instances (shared inputs)
  logic        s_rst_n, s_flush, s_in_valid, s_out_ready;
  logic [2:0]  s_op;
  logic [15:0] s_src0, s_src1;
  logic [31:0] s_acc;
  logic [4:0]  s_tag;
  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [15:0] a_res;
  logic [31:0] b_res;
  logic [4:0]  a_tag, b_tag;

  mult_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src0(src0), .src1(src1), .acc_in(acc), .tag_in(tag),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .tag_out(tag_out));

  mult_pipe #(.W(8), .STAGES(1), .TAG_W(5)) dut8 (
    .clk(clk), .rst_n(s_rst_n), .flush(s_flush), .in_valid(s_in_valid), .in_ready(a_in_ready),
    .op(s_op), .src0(s_src0[7:0]), .src1(s_src1[7:0]), .acc_in(s_acc[15:0]), .tag_in(s_tag),
    .out_valid(a_out_valid), .out_ready(s_out_ready), .res(a_res), .tag_out(a_tag));

  mult_pipe #(.W(16), .STAGES(4), .TAG_W(5)) dut16 (
    .clk(clk), .rst_n(s_rst_n), .flush(s_flush), .in_valid(s_in_valid), .in_ready(b_in_ready),
    .op(s_op), .src0(s_src0), .src1(s_src1), .acc_in(s_acc), .tag_in(s_tag),
    .out_valid(b_out_valid), .out_ready(s_out_ready), .res(b_res), .tag_out(b_tag));

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] acc;
    logic [4:0]  tag;
    logic [63:0] exp;
  } vec_t;
  vec_t tv [12];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference: plain wide multiply on extended operands.
  function automatic logic [127:0] model(input int w, input logic [2:0] o,
      input logic [63:0] a, input logic [63:0] b, input logic [127:0] ac);
    logic [127:0] lo_mask, mask, ea, eb, p, r;
    lo_mask = (128'd1 << w) - 128'd1;
    mask    = (128'd1 << (2*w)) - 128'd1;
    ea = {64'd0, a} & lo_mask;
    eb = {64'd0, b} & lo_mask;
    if (!o[0] && a[w-1]) ea = ea | ~lo_mask;
    if (!o[0] && b[w-1]) eb = eb | ~lo_mask;
    p = ea * eb;
    case (o)
      3'b010, 3'b011: r = ac + p;
      3'b100, 3'b101: r = ac - p;
      default:        r = p;
    endcase
    return r & mask;
  endfunction

  task automatic sw_rand(input int i, output logic [127:0] e8, output logic [127:0] e16,
                         output logic [4:0] t);
    logic [2:0]  o;
    logic [15:0] a, b;
    logic [31:0] ac;
    o  = 3'($urandom_range(0, 5));
    a  = 16'($urandom);
    b  = 16'($urandom);
    ac = $urandom;
    t  = 5'($urandom);
    if (i % 3 == 0) begin a = 16'h8080; b = 16'hFF80; end
    s_in_valid = 1'b1; s_op = o; s_src0 = a; s_src1 = b; s_acc = ac; s_tag = t;
    e8  = model(8,  o, {56'd0, a[7:0]}, {56'd0, b[7:0]}, {112'd0, ac[15:0]});
    e16 = model(16, o, {48'd0, a}, {48'd0, b}, {96'd0, ac});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] e8, e16, d8, d16;
    logic [127:0] x8 [8];
    logic [127:0] x16 [8];
    logic [4:0]   t, dt;
    logic [4:0]   xt [8];

    tv[0]  = '{3'b000, 32'hFFFFFFFF, 32'h00000002, 64'h0, 5'd1,  64'hFFFFFFFF_FFFFFFFE};
    tv[1]  = '{3'b001, 32'hFFFFFFFF, 32'h00000002, 64'h0, 5'd2,  64'h00000001_FFFFFFFE};
    tv[2]  = '{3'b000, 32'h80000000, 32'h80000000, 64'h0, 5'd3,  64'h40000000_00000000};
    tv[3]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 5'd4,  64'hFFFFFFFE_00000001};
    tv[4]  = '{3'b010, 32'h3, 32'h4, 64'h5, 5'd5,  64'h11};
    tv[5]  = '{3'b100, 32'h1, 32'h1, 64'h0, 5'd6,  64'hFFFFFFFF_FFFFFFFF};
    tv[6]  = '{3'b011, 32'h1, 32'h1, 64'hFFFFFFFF_FFFFFFFF, 5'd7, 64'h0};
    tv[7]  = '{3'b101, 32'hFFFFFFFF, 32'h1, 64'h00000001_00000000, 5'd8, 64'h1};
    tv[8]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h10, 5'd9, 64'h11};
    tv[9]  = '{3'b000, 32'h7FFFFFFF, 32'h80000000, 64'h0, 5'd10, 64'hC0000000_80000000};
    tv[10] = '{3'b110, 32'hFFFFFFFF, 32'h00000002, 64'h123, 5'd11, 64'hFFFFFFFF_FFFFFFFE};
    tv[11] = '{3'b100, 32'h3, 32'hFFFFFFFE, 64'h5, 5'd12, 64'hB};

    rst_n = 0; flush = 0; in_valid = 0; op = 0; src0 = 0; src1 = 0; acc = 0; tag = 0; out_ready = 1;
    s_rst_n = 0; s_flush = 0; s_in_valid = 0; s_op = 0; s_src0 = 0; s_src1 = 0; s_acc = 0;
    s_tag = 0; s_out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1; s_rst_n = 1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_res", res, 0);
    check("rst_tag", tag_out, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_w8_out_valid", a_out_valid, 0);
    check("rst_w16_out_valid", b_out_valid, 0);
    check("rst_w16_in_ready", b_in_ready, 1);

    // Directed vectors, one at a time: latency 2, result, tag.
    foreach (tv[i]) begin
      @(posedge clk); #1;
      in_valid = 1; op = tv[i].op; src0 = tv[i].a; src1 = tv[i].b; acc = tv[i].acc; tag = tv[i].tag;
      @(posedge clk); #1;
      in_valid = 0;
      @(negedge clk);
      check($sformatf("vec%0d_early", i), out_valid, 0);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_res", i), res, tv[i].exp);
      check($sformatf("vec%0d_tag", i), tag_out, tv[i].tag);
    end

    // Backpressure: 6 back-to-back MULTU ops, out_ready low in cycles 3..5.
    begin
      int k, r;
      logic stall_prev;
      logic [63:0] pres;
      logic [4:0] ptag;
      k = 0; r = 0; stall_prev = 0; pres = 0; ptag = 0;
      for (int c = 0; c < 16; c++) begin
        @(posedge clk); #1;
        out_ready = !(c >= 3 && c <= 5);
        in_valid  = (k < 6);
        op = 3'b001; src0 = 32'(k + 1); src1 = 32'd3; acc = 0; tag = 5'(k + 8);
        @(negedge clk);
        if (c >= 3 && c <= 5) check("bp_in_ready", in_ready, 0);
        if (stall_prev) begin
          check("bp_res_stable", res, pres);
          check("bp_tag_stable", tag_out, ptag);
        end
        if (out_valid && out_ready) begin
          if (r < 6) begin
            check($sformatf("bp_res%0d", r), res, 64'((r + 1) * 3));
            check($sformatf("bp_tag%0d", r), tag_out, 5'(r + 8));
          end
          r++;
        end
        stall_prev = out_valid && !out_ready;
        pres = res; ptag = tag_out;
        if (in_valid && in_ready) k++;
      end
      check("bp_count", r, 6);
      in_valid = 0; out_ready = 1;
    end

    // Flush: A, B accepted; flush while C presented (and A at the output).
    @(posedge clk); #1;
    in_valid = 1; op = 3'b000; src0 = 2; src1 = 3; acc = 0; tag = 5'd1;
    @(posedge clk); #1;
    src0 = 4; src1 = 5; tag = 5'd2;
    @(posedge clk); #1;
    src0 = 6; src1 = 7; tag = 5'd3; flush = 1;
    @(negedge clk);
    check("fl_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 0; op = 3'b001; src0 = 9; src1 = 9; tag = 5'd4;
    @(negedge clk);
    check("fl_out_valid_c3", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    check("fl_out_valid_c4", out_valid, 0);
    @(negedge clk);
    check("fl_d_valid", out_valid, 1);
    check("fl_d_res", res, 64'd81);
    check("fl_d_tag", tag_out, 5'd4);
    @(negedge clk);
    check("fl_out_valid_c6", out_valid, 0);

    // Sweep: single random ops, latency 1 (W=8) and 4 (W=16).
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      sw_rand(i, e8, e16, t);
      for (int c = 0; c < 6; c++) begin
        if (c > 0) begin
          @(posedge clk); #1;
          s_in_valid = 0;
        end
        @(negedge clk);
        check("w8_valid", a_out_valid, c == 1);
        check("w16_valid", b_out_valid, c == 4);
        if (c == 1) begin
          check($sformatf("w8_res%0d", i), a_res, e8);
          check("w8_tag", a_tag, t);
        end
        if (c == 4) begin
          check($sformatf("w16_res%0d", i), b_res, e16);
          check("w16_tag", b_tag, t);
        end
      end
    end

    // Sweep: back-to-back stream of 8, out_ready held high.
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (c < 8) sw_rand(c, x8[c], x16[c], xt[c]);
      else s_in_valid = 0;
      @(negedge clk);
      check("w8_st_valid", a_out_valid, c >= 1 && c <= 8);
      check("w16_st_valid", b_out_valid, c >= 4 && c <= 11);
      if (c >= 1 && c <= 8) begin
        check($sformatf("w8_st_res%0d", c - 1), a_res, x8[c-1]);
        check("w8_st_tag", a_tag, xt[c-1]);
      end
      if (c >= 4 && c <= 11) begin
        check($sformatf("w16_st_res%0d", c - 4), b_res, x16[c-4]);
        check("w16_st_tag", b_tag, xt[c-4]);
      end
    end

    // Sweep: reset mid-stream.
    d8 = 0; d16 = 0; dt = 0;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      s_rst_n = (c != 4);
      if (c <= 5) sw_rand(c, d8, d16, dt);
      else s_in_valid = 0;
      @(negedge clk);
      if (c == 4) begin
        check("mr_w8_valid_pre", a_out_valid, 1);
        check("mr_w16_valid_pre", b_out_valid, 1);
      end
      if (c == 5) begin
        check("mr_w8_valid", a_out_valid, 0);
        check("mr_w16_valid", b_out_valid, 0);
        check("mr_w8_res", a_res, 0);
        check("mr_w16_res", b_res, 0);
        check("mr_w16_tag", b_tag, 0);
      end
      if (c == 6) begin
        check("mr_w8_after", a_out_valid, 1);
        check("mr_w8_after_res", a_res, d8);
      end
      if (c >= 6) check("mr_w16_lost", b_out_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
